// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - request/response port bundle for one dmem_arbiter master
//
// Purpose: groups one master's handshake with the data-memory arbiter.
//   master modport : the requester (CPU LSU or loader/DMA) side
//   slave  modport : the arbiter side
// Signals:
//   req   master -> arbiter  request, held until ack
//   we    master -> arbiter  1=store, 0=load
//   addr  master -> arbiter  64-bit byte address
//   wdata master -> arbiter  64-bit store data
//   rdata arbiter -> master  load data, valid while ack=1
//   ack   arbiter -> master  one-cycle completion pulse
//   err   arbiter -> master  error flag, valid while ack=1
interface dmem_arbiter_if;
  logic        req;
  logic        we;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic [63:0] rdata;
  logic        ack;
  logic        err;

  modport master (output req, we, addr, wdata, input rdata, ack, err);
  modport slave  (input req, we, addr, wdata, output rdata, ack, err);
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-master arbiter/sequencer for the single-ported data memory
//
// Purpose: serialises 8-byte load/store requests from master 0 (CPU LSU) and
// master 1 (program loader / debug DMA) onto one memory with a bidirectional
// data bus, negedge write commit and combinational read. Misaligned or
// out-of-range requests are answered with err=1 without touching memory.
// Each transaction takes IDLE -> ACCESS -> RESP (errors skip ACCESS).
//
// Optional feature macro: DMEM_ARB_RR_EN
//   defined   : round-robin arbitration with a 1-bit last-grant pointer
//   undefined : fixed priority, master 0 over master 1
//
// Ports:
//   clk      in     system clock, all state on posedge
//   rst      in     asynchronous active-high reset
//   m0, m1   slave  dmem_arbiter_if request/response bundles
//   mem_rw   out    1=write, 0=read; only ever 1 during ACCESS
//   mem_addr out    64-bit memory byte address
//   mem_data inout  64-bit data bus, driven here only while mem_rw=1
module dmem_arbiter #(
  parameter int unsigned SIZE      = 8192,
  parameter int unsigned ALIGN_CHK = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  dmem_arbiter_if.slave         m0,
  dmem_arbiter_if.slave         m1,
  output logic                  mem_rw,
  output logic [63:0]           mem_addr,
  inout  wire  [63:0]           mem_data
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      state_q;
  logic        id_q;
  logic        we_q;
  logic [63:0] wdata_q;
  logic        mem_rw_q;
  logic [63:0] mem_addr_q;
  logic [63:0] rdata0_q, rdata1_q;
  logic        ack0_q, ack1_q;
  logic        err0_q, err1_q;
`ifdef DMEM_ARB_RR_EN
  // 1 = master 1 was granted last; reset value lets master 0 win the first tie.
  logic        last_q;
`endif

  // Winner selection and fields to latch at grant.
  logic        id_d;
  logic        we_d;
  logic [63:0] addr_d;
  logic [63:0] wdata_d;
  logic        err_d;

  always_comb begin
    id_d = 1'b0;
`ifdef DMEM_ARB_RR_EN
    id_d = m1.req & (~m0.req | ~last_q);
`else
    id_d = m1.req & ~m0.req;
`endif
    we_d    = id_d ? m1.we    : m0.we;
    addr_d  = id_d ? m1.addr  : m0.addr;
    wdata_d = id_d ? m1.wdata : m0.wdata;
    // The last legal 8-byte access starts at SIZE-8.
    err_d   = ((ALIGN_CHK != 0) && (addr_d[2:0] != 3'b000)) ||
              (addr_d > 64'(SIZE - 8));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      id_q       <= 1'b0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      mem_rw_q   <= 1'b0;
      mem_addr_q <= '0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      err0_q     <= 1'b0;
      err1_q     <= 1'b0;
`ifdef DMEM_ARB_RR_EN
      last_q     <= 1'b1;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (m0.req || m1.req) begin
            id_q    <= id_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
`ifdef DMEM_ARB_RR_EN
            last_q  <= id_d;
`endif
            if (err_d) begin
              // Rejected: answer straight away, memory bus stays idle.
              state_q <= RESP;
              ack0_q  <= ~id_d;
              ack1_q  <= id_d;
              err0_q  <= ~id_d;
              err1_q  <= id_d;
            end else begin
              state_q    <= ACCESS;
              mem_rw_q   <= we_d;
              mem_addr_q <= addr_d;
            end
          end
        end
        ACCESS: begin
          state_q  <= RESP;
          mem_rw_q <= 1'b0;
          // Memory read is combinational, so the bus holds load data now.
          if (!we_q) begin
            if (id_q) rdata1_q <= mem_data;
            else      rdata0_q <= mem_data;
          end
          ack0_q <= ~id_q;
          ack1_q <= id_q;
        end
        RESP: begin
          state_q  <= IDLE;
          ack0_q   <= 1'b0;
          ack1_q   <= 1'b0;
          err0_q   <= 1'b0;
          err1_q   <= 1'b0;
          rdata0_q <= '0;
          rdata1_q <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_rw   = mem_rw_q;
  assign mem_addr = mem_addr_q;
  assign mem_data = mem_rw_q ? wdata_q : 64'bz;

  assign m0.rdata = rdata0_q;
  assign m0.ack   = ack0_q;
  assign m0.err   = err0_q;
  assign m1.rdata = rdata1_q;
  assign m1.ack   = ack1_q;
  assign m1.err   = err1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter with a behavioural memory
module tb_dmem_arbiter;

  localparam int unsigned SIZE  = 8192;
  localparam int unsigned WORDS = SIZE / 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_rw;
  logic [63:0] mem_addr;
  wire  [63:0] mem_data;

  dmem_arbiter_if m0_if ();
  dmem_arbiter_if m1_if ();

  dmem_arbiter #(.SIZE(SIZE), .ALIGN_CHK(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .m0       (m0_if),
    .m1       (m1_if),
    .mem_rw   (mem_rw),
    .mem_addr (mem_addr),
    .mem_data (mem_data)
  );

  always #5 clk = ~clk;

  // Behavioural memory: combinational read, write committed at negedge.
  logic [63:0] mem_w [WORDS];
  logic [63:0] rd_word;
  always_comb rd_word = (mem_addr < 64'(SIZE)) ? mem_w[mem_addr[12:3]] : 64'h0;
  assign mem_data = mem_rw ? 64'bz : rd_word;
  always @(negedge clk) if (mem_rw) mem_w[mem_addr[12:3]] = mem_data;

  typedef struct {
    bit          id;
    logic [63:0] rdata;
    bit          err;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   rw_seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge mem_rw) rw_seen = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: pop the scoreboard on every ack.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (m0_if.ack || m1_if.ack)) begin
      chk("single_ack", {63'd0, m0_if.ack & m1_if.ack}, 64'd0);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ack actual=m0:%0b/m1:%0b required=none", m0_if.ack, m1_if.ack);
      end else begin
        e = exp_q.pop_front();
        chk("ack_id", {63'd0, m1_if.ack}, {63'd0, e.id});
        chk("rdata", m1_if.ack ? m1_if.rdata : m0_if.rdata, e.rdata);
        chk("err", {63'd0, m1_if.ack ? m1_if.err : m0_if.err}, {63'd0, e.err});
        chk("ack_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic set_req(input bit id, input bit v, input bit we,
                         input logic [63:0] addr, input logic [63:0] wdata);
    if (id) begin
      m1_if.req = v; m1_if.we = we; m1_if.addr = addr; m1_if.wdata = wdata;
    end else begin
      m0_if.req = v; m0_if.we = we; m0_if.addr = addr; m0_if.wdata = wdata;
    end
  endtask

  task automatic do_req(input bit id, input bit we, input logic [63:0] addr,
                        input logic [63:0] wdata, input logic [63:0] rdata_exp,
                        input bit err_exp);
    exp_t e;
    int   n;
    bit   seen;
    @(posedge clk); #1;
    e.id = id; e.rdata = rdata_exp; e.err = err_exp;
    e.cyc = cyc + (err_exp ? 1 : 2);
    exp_q.push_back(e);
    set_req(id, 1'b1, we, addr, wdata);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      seen = id ? m1_if.ack : m0_if.ack;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL ack_timeout actual=no_ack required=ack addr=%h", addr);
    end
    @(posedge clk); #1;
    set_req(id, 1'b0, 1'b0, 64'h0, 64'h0);
  endtask

  localparam logic [63:0] W0   = 64'hA0A0_0000_1111_A0A0;
  localparam logic [63:0] W1   = 64'hB1B1_2222_3333_B1B1;
  localparam logic [63:0] OLD  = 64'hDEAD_BEEF_0BAD_F00D;
  localparam logic [63:0] D10  = 64'h0011_2233_4455_6677;
  localparam logic [63:0] DTOP = 64'h8877_6655_4433_2211;

  initial begin
    int n, acks, k;
    exp_t e;
    for (int i = 0; i < int'(WORDS); i++) mem_w[i] = 64'h0;
    mem_w[0] = W0;
    mem_w[1] = W1;
    mem_w[4] = OLD;
    set_req(1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
    set_req(1'b1, 1'b0, 1'b0, 64'h0, 64'h0);

    repeat (3) @(posedge clk);
    #1;
    chk("reset_m0_ack", {63'd0, m0_if.ack}, 64'd0);
    chk("reset_m1_ack", {63'd0, m1_if.ack}, 64'd0);
    chk("reset_m0_rdata", m0_if.rdata, 64'd0);
    chk("reset_mem_rw", {63'd0, mem_rw}, 64'd0);
    chk("reset_mem_addr", mem_addr, 64'd0);
    rst = 1'b0;

    // Reset while a store sits in ACCESS, before its negedge commit.
    @(posedge clk); #1;
    set_req(1'b0, 1'b1, 1'b1, 64'h20, 64'h5555_AAAA_5555_AAAA);
    @(posedge clk); #1;
    chk("midwr_in_access", {63'd0, mem_rw}, 64'd1);
    rst = 1'b1;
    #1;
    chk("midwr_mem_rw", {63'd0, mem_rw}, 64'd0);
    chk("midwr_mem_addr", mem_addr, 64'd0);
    chk("midwr_state", 64'(dut.state_q), 64'd0);
    set_req(1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midwr_mem_unchanged", mem_w[4], OLD);

    // Store then load through master 0.
    do_req(1'b0, 1'b1, 64'h10, D10, 64'h0, 1'b0);
    chk("store_committed", mem_w[2], D10);
    do_req(1'b0, 1'b0, 64'h10, 64'h0, D10, 1'b0);

    // Misaligned master 1 load: error without any memory access.
    rw_seen = 1'b0;
    do_req(1'b1, 1'b0, 64'h13, 64'h0, 64'h0, 1'b1);
    chk("misaligned_no_rw", {63'd0, rw_seen}, 64'd0);

    // Past-the-end store.
    rw_seen = 1'b0;
    do_req(1'b0, 1'b1, 64'h1FFC, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1);
    chk("oor_no_rw", {63'd0, rw_seen}, 64'd0);
    chk("oor_mem_unchanged", mem_w[WORDS-1], 64'h0);

    // Highest legal address.
    do_req(1'b0, 1'b1, 64'h1FF8, DTOP, 64'h0, 1'b0);
    do_req(1'b0, 1'b0, 64'h1FF8, 64'h0, DTOP, 1'b0);

    // Master 1 load; also leaves the round-robin pointer at master 1.
    do_req(1'b1, 1'b0, 64'h8, 64'h0, W1, 1'b0);

    // Both masters request continuously.
    @(posedge clk); #1;
    k = cyc;
    for (int i = 0; i < 4; i++) begin
`ifdef DMEM_ARB_RR_EN
      e.id = i[0];
`else
      e.id = 1'b0;
`endif
      e.rdata = e.id ? W1 : W0;
      e.err = 1'b0;
      e.cyc = k + 2 + 3 * i;
      exp_q.push_back(e);
    end
    set_req(1'b0, 1'b1, 1'b0, 64'h0, 64'h0);
    set_req(1'b1, 1'b1, 1'b0, 64'h8, 64'h0);
    acks = 0;
    n = 0;
    while (acks < 4 && n < 40) begin
      @(negedge clk);
      n++;
      if (m0_if.ack || m1_if.ack) acks++;
    end
    chk("contention_acks", 64'(acks), 64'd4);
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
    set_req(1'b1, 1'b0, 1'b0, 64'h0, 64'h0);

    repeat (5) @(posedge clk);
    #1;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-master arbiter and sequencer for the single-ported byte-addressed data memory (8-byte accesses, bidirectional 64-bit data bus, negedge write commit, combinational read).
- Master 0 is the CPU load/store unit; master 1 is the program loader / debug DMA port.
- Serialises requests, drives the memory's mem_rw, addr and mem_data, registers read data, and rejects misaligned or out-of-range accesses without touching memory.

Parameters:
- SIZE, 8192, memory size in bytes; must match the memory's Size.
- ALIGN_CHK, 1, when 1, an address with addr[2:0]!=0 is an error.

Ports:
- clk  input  1  system clock; all state on posedge.
- rst  input  1  asynchronous, active-high reset.
- m0_req  input  1  master 0 request; held until m0_ack.
- m0_we  input  1  master 0: 1=store, 0=load.
- m0_addr  input  64  master 0 byte address.
- m0_wdata  input  64  master 0 store data.
- m0_rdata  output  64  master 0 load data, valid while m0_ack=1.
- m0_ack  output  1  master 0 one-cycle completion pulse.
- m0_err  output  1  master 0 error flag, valid while m0_ack=1.
- m1_req, m1_we, m1_addr, m1_wdata, m1_rdata, m1_ack, m1_err: same as m0_*.
- mem_rw  output  1  to memory: 1=write, 0=read.
- mem_addr  output  64  to memory address.
- mem_data  inout  64  memory data bus; driven by the arbiter only when mem_rw=1, else high-Z.

Behaviour:
- Reset, asynchronous and immediate:
  - state=IDLE; mem_rw=0; mem_addr=0; mem_data=Z.
  - All ack, err and rdata outputs =0.
  - The RR pointer favours m0.
  - A write in ACCESS not yet committed at negedge is dropped.
- States:
  - IDLE -> ACCESS or RESP on any req.
  - ACCESS -> RESP.
  - RESP -> IDLE.
- IDLE:
  - Sample reqs at posedge and pick a winner; without the optional feature m0 always wins.
  - Latch the winner's id, we, addr and wdata.
  - Error if (ALIGN_CHK && addr[2:0]!=0) or addr > SIZE-8. On error go to RESP with err set and skip ACCESS.
  - Otherwise go to ACCESS.
- ACCESS (exactly 1 cycle):
  - mem_addr=latched addr; mem_rw=latched we.
  - If we, drive latched wdata onto mem_data; the memory commits at this cycle's negedge.
  - At the closing posedge, capture mem_data into the winner's rdata for loads; stores leave rdata=0.
- RESP (1 cycle):
  - Winner's ack=1; err as determined; loser's ack=0.
  - mem_rw=0; mem_data=Z; mem_addr holds its value.
- Error response: ack=1, err=1, rdata=0, mem_rw never asserted.
- Latency: req seen at edge N -> ack high during cycle N+2 (N+1 on error). At most one transaction every 3 cycles.
- Requester rule: after seeing ack at a posedge, deassert req or present a new request. IDLE re-samples on the next edge, so there is no double grant.
- A non-winning master keeps req high and is served after the current transaction.
- Request inputs are ignored outside IDLE.
- Changing addr, we or wdata while req is pending and not yet granted is allowed; values are latched at grant.
- mem_rw is never 1 outside ACCESS, so there is no bus contention with memory read drive.

Optional Feature:
- Macro: DMEM_ARB_RR_EN.
- Defined: round-robin between masters. A 1-bit last-grant pointer updates on every grant, including error responses. When both masters request, the non-last master wins. After reset m0 wins the first tie.
- Undefined: fixed priority, m0 over m1; m1 can starve while m0 requests continuously.

Test Plan:
- Reset mid-write: m0 store asserted, rst pulsed in ACCESS before negedge -> outputs zero, memory at addr unchanged, state IDLE.
- m0 store 0x0011223344556677 to 0x10, then m0 load 0x10 -> load ack 2 cycles after req, rdata=0x0011223344556677, err=0.
- Misaligned m1 load at 0x13 -> m1_ack next cycle, err=1, rdata=0, mem_rw stays 0.
- Out-of-range m0 store at SIZE-4 (0x1FFC) -> err=1, memory unchanged.
- Out-of-range boundary: store at 0x1FF8 -> err=0, readback matches.
- m0 and m1 both request loads from 0x0 and 0x8 continuously:
  - Without DMEM_ARB_RR_EN, only m0 is acked.
  - With DMEM_ARB_RR_EN, acks alternate m0, m1, m0, m1, one every 3 cycles.
